// File: rtl/comp_nbit_seq.sv
// Iterative MSB-first magnitude comparator, STEP bits per clock, unsigned or two's-complement.
// Optional build macro COMP_EARLY_EXIT_EN: finish as soon as the first differing chunk is seen.
module comp_nbit_seq #(
  parameter int WIDTH = 8,
  parameter int STEP  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sgn,
  output logic             busy,
  output logic             done,
  output logic             E,
  output logic             G,
  output logic             L
);

  localparam int NSTEP = WIDTH / STEP;
  localparam int IDXW  = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSTEP - 1);

  generate
    if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_param
      $error("comp_nbit_seq: WIDTH must be >= 2 and divisible by STEP");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [WIDTH-1:0] a_r, b_r;
  logic [IDXW-1:0] idx;
  logic            eq_r, gt_r, lt_r;
  logic            c_eq, c_gt, c_lt;
  logic            nxt_eq, nxt_gt, nxt_lt;
  logic            exit_now;

  // Operands shift left each RUN cycle, so chunk idx always sits in the top STEP bits.
  always_comb begin
    c_eq = 1'b1;
    c_gt = 1'b0;
    c_lt = 1'b0;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (c_eq && (a_r[WIDTH-1-i] != b_r[WIDTH-1-i])) begin
        c_gt = a_r[WIDTH-1-i];
        c_lt = b_r[WIDTH-1-i];
        c_eq = 1'b0;
      end
    end
  end

  always_comb begin
    nxt_eq = eq_r & c_eq;
    nxt_gt = gt_r | (eq_r & c_gt);
    nxt_lt = lt_r | (eq_r & c_lt);
`ifdef COMP_EARLY_EXIT_EN
    exit_now = eq_r & ~c_eq;
`else
    exit_now = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      idx   <= '0;
      eq_r  <= 1'b0;
      gt_r  <= 1'b0;
      lt_r  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      E     <= 1'b0;
      G     <= 1'b0;
      L     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Flipping the sign bit maps two's-complement onto an unsigned order.
            a_r   <= {A[WIDTH-1] ^ sgn, A[WIDTH-2:0]};
            b_r   <= {B[WIDTH-1] ^ sgn, B[WIDTH-2:0]};
            idx   <= IDX_TOP;
            eq_r  <= 1'b1;
            gt_r  <= 1'b0;
            lt_r  <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_r  <= a_r << STEP;
          b_r  <= b_r << STEP;
          eq_r <= nxt_eq;
          gt_r <= nxt_gt;
          lt_r <= nxt_lt;
          if (idx == '0 || exit_now) begin
            E     <= nxt_eq;
            G     <= nxt_gt;
            L     <= nxt_lt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comp_nbit_seq.sv
// Directed bench for comp_nbit_seq: 8-bit/STEP=2 instance plus an exhaustive 2-bit/STEP=1 instance.
module tb_comp_nbit_seq;

`ifdef COMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start, sgn;
  logic [7:0] A, B;
  logic       busy, done, E, G, L;

  logic       s_start, s_sgn;
  logic [1:0] s_A, s_B;
  logic       s_busy, s_done, s_E, s_G, s_L;

  int n_checks = 0;
  int n_fail   = 0;

  comp_nbit_seq #(.WIDTH(8), .STEP(2)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .sgn(sgn),
    .busy(busy), .done(done), .E(E), .G(G), .L(L)
  );

  comp_nbit_seq #(.WIDTH(2), .STEP(1)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .A(s_A), .B(s_B), .sgn(s_sgn),
    .busy(s_busy), .done(s_done), .E(s_E), .G(s_G), .L(s_L)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Launch one compare on the 8-bit DUT; returns to the negedge of the done cycle.
  // lat counts the start cycle, 0 if done never came.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output int lat, output int bcnt);
    @(negedge clk);
    A = a; B = b; sgn = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bcnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (done) begin
        lat = n + 1;
        break;
      end
      if (busy) bcnt++;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; A = '0; B = '0;
    s_start = 1'b0; s_sgn = 1'b0; s_A = '0; s_B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, E, G, L} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected 00000", {busy, done, E, G, L});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, E, G, L, s_busy, s_done, s_E, s_G, s_L} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected 0000000000",
               {busy, done, E, G, L, s_busy, s_done, s_E, s_G, s_L});
    end
  endtask

  task automatic test_equal;
    int lat, bc;
    run_op(8'hA5, 8'hA5, 1'b0, lat, bc);
    n_checks++;
    if (lat !== 5) begin n_fail++; $display("FAIL eq_latency: got %0d expected 5", lat); end
    n_checks++;
    if (bc !== 4) begin n_fail++; $display("FAIL eq_busy_cycles: got %0d expected 4", bc); end
    n_checks++;
    if ({E, G, L} !== 3'b100) begin n_fail++; $display("FAIL eq_result: got %b expected 100", {E, G, L}); end
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL eq_done_single: busy,done got %b expected 00", {busy, done});
    end
  endtask

  task automatic test_compare_table;
    logic [7:0] ta [7] = '{8'hA5, 8'h80, 8'h80, 8'hFF, 8'h7F, 8'hFE, 8'h01};
    logic [7:0] tb [7] = '{8'hA5, 8'h7F, 8'h7F, 8'h01, 8'h80, 8'hFF, 8'h02};
    logic       ts [7] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0};
    logic [2:0] te [7] = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b010, 3'b001, 3'b001};
    int lat, bc;
    for (int i = 0; i < 7; i++) begin
      run_op(ta[i], tb[i], ts[i], lat, bc);
      n_checks++;
      if (lat == 0 || {E, G, L} !== te[i]) begin
        n_fail++;
        $display("FAIL cmp_%0d A=%h B=%h sgn=%b: EGL got %b expected %b (lat %0d)",
                 i, ta[i], tb[i], ts[i], {E, G, L}, te[i], lat);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    A = 8'h80; B = 8'h7F; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    A = 8'h00; B = 8'hFF;
    lat = 0;
    for (int n = 0; n < 40; n++) begin
      if (done) begin lat = n + 1; break; end
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (lat == 0 || {E, G, L} !== 3'b010) begin
      n_fail++;
      $display("FAIL hold_start_captured: EGL got %b expected 010 (lat %0d)", {E, G, L}, lat);
    end
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL start_in_done_ignored: busy,done got %b expected 00", {busy, done});
    end
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_after_done_accepted: busy got %b expected 1", busy);
    end
    lat = 0;
    for (int n = 0; n < 40; n++) begin
      if (done) begin lat = n + 1; break; end
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (lat == 0 || {E, G, L} !== 3'b001) begin
      n_fail++;
      $display("FAIL second_op_result: EGL got %b expected 001 (lat %0d)", {E, G, L}, lat);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat, bc, dcnt;
    @(negedge clk);
    A = 8'h33; B = 8'h33; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, E, G, L} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got %b expected 00000", {busy, done, E, G, L});
    end
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    n_checks++;
    if (dcnt !== 0) begin
      n_fail++;
      $display("FAIL reset_no_done: activity cycles got %0d expected 0", dcnt);
    end
    run_op(8'h5A, 8'h5A, 1'b0, lat, bc);
    n_checks++;
    if (lat !== 5 || {E, G, L} !== 3'b100) begin
      n_fail++;
      $display("FAIL after_reset_op: lat %0d EGL %b expected lat 5 EGL 100", lat, {E, G, L});
    end
  endtask

  task automatic test_early_exit;
    int lat, bc;
    run_op(8'h80, 8'h00, 1'b0, lat, bc);
    n_checks++;
    if (lat !== (EE ? 2 : 5) || {E, G, L} !== 3'b010) begin
      n_fail++;
      $display("FAIL early_msb_diff: lat %0d EGL %b expected lat %0d EGL 010",
               lat, {E, G, L}, EE ? 2 : 5);
    end
    run_op(8'h01, 8'h02, 1'b0, lat, bc);
    n_checks++;
    if (lat !== 5 || {E, G, L} !== 3'b001) begin
      n_fail++;
      $display("FAIL early_lsb_diff: lat %0d EGL %b expected lat 5 EGL 001", lat, {E, G, L});
    end
  endtask

  task automatic test_hold_results;
    @(negedge clk);
    A = 8'hFF; B = 8'h00; sgn = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({done, E, G, L} !== 4'b0001) begin
      n_fail++;
      $display("FAIL result_hold: done,EGL got %b expected 0001", {done, E, G, L});
    end
  endtask

  task automatic test_small_exhaustive;
    int ra, rb, lat, elat;
    logic [2:0] exp;
    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 16; v++) begin
        @(negedge clk);
        s_A = v[3:2]; s_B = v[1:0]; s_sgn = s[0]; s_start = 1'b1;
        ra = (s == 1 && v[3]) ? int'(v[3:2]) - 4 : int'(v[3:2]);
        rb = (s == 1 && v[1]) ? int'(v[1:0]) - 4 : int'(v[1:0]);
        exp  = (ra == rb) ? 3'b100 : (ra > rb) ? 3'b010 : 3'b001;
        elat = (EE && (v[3] != v[1])) ? 2 : 3;
        @(posedge clk);
        @(negedge clk);
        s_start = 1'b0;
        lat = 0;
        for (int n = 0; n < 20; n++) begin
          if (s_done) begin lat = n + 1; break; end
          @(posedge clk);
          @(negedge clk);
        end
        n_checks++;
        if ({s_E, s_G, s_L} !== exp || lat !== elat) begin
          n_fail++;
          $display("FAIL small A=%0d B=%0d sgn=%0d: EGL %b lat %0d expected EGL %b lat %0d",
                   v[3:2], v[1:0], s, {s_E, s_G, s_L}, lat, exp, elat);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_equal;
    test_compare_table;
    test_back_to_back;
    test_reset_mid_run;
    test_early_exit;
    test_hold_results;
    test_small_exhaustive;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/comp_nbit_seq.md
Name: comp_nbit_seq

Overview:
Parametrised iterative magnitude comparator: the successor to the fixed 2-bit combinational comparator.
Captures two WIDTH-bit operands on a start pulse and compares them MSB-first, STEP bits per clock, using a chained 1-bit-compare slice.
Supports unsigned and two's-complement modes, with a start/busy/done handshake.
Registered E/G/L results are held until the next completion; sits beside the datapath wherever wide compares are not timing-critical.

Parameters:
WIDTH, 8, operand width in bits; must be at least 2.
STEP, 2, bits compared per cycle; WIDTH must be divisible by STEP (elaboration error otherwise).
NSTEP (localparam), WIDTH/STEP, number of compare slices.

Ports:
clk  input  1  single system clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request; sampled only while busy=0.
A  input  WIDTH  operand A; sampled with start.
B  input  WIDTH  operand B; sampled with start.
sgn  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  one-cycle completion pulse.
E  output  1  registered result: A == B.
G  output  1  registered result: A > B.
L  output  1  registered result: A < B.

Behaviour:
- Reset (async assert, any state): state=IDLE, busy=0, done=0, E=0, G=0, L=0, internal operand/index/flag registers cleared.
- Reset deassertion: synchronous to clk.
- Reset mid-operation: aborts the compare with no done pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start=1, capture A, B and sgn into registers. When sgn=1, invert the MSB of both captured operands (offset-binary mapping). Set idx=NSTEP-1, eq_r=1, gt_r=0, lt_r=0, go to RUN, busy=1.
  - RUN: each cycle examine chunk idx (bits idx*STEP+STEP-1 .. idx*STEP) of both operands. If eq_r=1 and the chunks differ, set gt_r/lt_r from the chunk magnitude compare and clear eq_r. Once eq_r=0, later chunks never change the result. Decrement idx. After processing idx=0, go to DONE.
  - DONE: done=1 for exactly this cycle. E/G/L are loaded from eq_r/gt_r/lt_r at the edge entering DONE. busy=0 in DONE. Return to IDLE.
- Latency (no early exit): start sampled at edge k; done is high in the cycle after edge k+NSTEP; total NSTEP+1 cycles.
- Back-to-back operation: a start in the DONE cycle is ignored. A start in the IDLE cycle immediately after is accepted.
- start while busy=1: ignored; operands are not re-captured.
- Result invariant: exactly one of E/G/L is 1 after the first completion. All three are 0 only after reset.
- Results hold their values until the next DONE entry. Inputs may change freely after capture.
- Wrap-around: idx does not underflow; the RUN->DONE transition is taken when idx==0.

Optional Feature:
COMP_EARLY_EXIT_EN
- Defined: in RUN, when the current chunk differs (eq_r was 1), go to DONE on that edge with the final result. Latency = j+1 cycles, where j is the 1-based index of the first differing chunk from the MSB. Equal operands still take NSTEP+1 cycles.
- Undefined: fixed NSTEP+1 latency regardless of data; the result is identical in both builds.

Test Plan:
- WIDTH=8, STEP=2, sgn=0, A=0xA5, B=0xA5, start pulse -> busy for 4 cycles, done pulse 5 cycles after start, E=1 G=0 L=0.
- A=0x80, B=0x7F: sgn=0 -> G=1; repeat with sgn=1 -> L=1 (-128 < 127). Also A=0xFF, B=0x01, sgn=1 -> L=1.
- Start held high while busy, A/B changed to 0x00/0xFF mid-RUN -> single done, result reflects the originally captured operands; next accepted start only after DONE.
- Assert rst during RUN (2nd cycle) -> outputs immediately 0, no done pulse. Fresh start afterwards -> normal 5-cycle completion.
- With COMP_EARLY_EXIT_EN: A=0x80, B=0x00 -> done 2 cycles after start, G=1. A=0x01, B=0x02 -> done 5 cycles after start, L=1. Without the macro, both take 5 cycles.
- WIDTH=2, STEP=1: exhaustive {A,B}=0..15, sgn=0 and sgn=1 -> E/G/L match a reference compare for all 32 cases; latency 3 cycles each.
